// File: rtl/uart_result_streamer.sv
// Streams every systolic-array accumulator to the host as UART 8N1 frames:
// one sync byte, then all words in address order, each little-endian.
module uart_result_streamer #(
  parameter int          MATRIX_SIZE    = 8,
  parameter int          ACC_WIDTH      = 32,
  parameter int          CLK_PER_BIT    = 54,
  parameter int          RD_LATENCY     = 1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_out,
  output logic                      uart_tx
);

  localparam int N_WORDS        = MATRIX_SIZE*MATRIX_SIZE;
  localparam int BYTES_PER_WORD = ACC_WIDTH/8;
  localparam int BAUD_W         = $clog2(CLK_PER_BIT);
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int LAT_W          = $clog2(RD_LATENCY+1);

  localparam logic [BAUD_W-1:0]         BAUD_LAST = BAUD_W'(CLK_PER_BIT-1);
  localparam logic [BIDX_W-1:0]         BYTE_LAST = BIDX_W'(BYTES_PER_WORD-1);
  localparam logic [LAT_W-1:0]          LAT_LAST  = LAT_W'(RD_LATENCY-1);
  localparam logic [ACC_ADDR_WIDTH-1:0] ADDR_LAST = ACC_ADDR_WIDTH'(N_WORDS-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t                    state, state_n;
  logic [BAUD_W-1:0]         baud_cnt, baud_n;
  logic [3:0]                bit_cnt, bit_n;
  logic [7:0]                shift_reg, shift_n;
  logic [ACC_WIDTH-1:0]      word_reg, word_n;
  logic [BIDX_W-1:0]         byte_idx, byte_n, byte_inc;
  logic [LAT_W-1:0]          lat_cnt, lat_n;
  logic [ACC_ADDR_WIDTH-1:0] addr_n;
  logic                      tx_n;
  logic                      frame_done;

  assign byte_inc = byte_idx + 1'b1;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      byte_idx  <= '0;
      lat_cnt   <= '0;
      addr_acc  <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      word_reg  <= word_n;
      byte_idx  <= byte_n;
      lat_cnt   <= lat_n;
      addr_acc  <= addr_n;
      uart_tx   <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_n     = baud_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift_reg;
    word_n     = word_reg;
    byte_n     = byte_idx;
    lat_n      = lat_cnt;
    addr_n     = addr_acc;
    tx_n       = uart_tx;
    frame_done = 1'b0;

    // Bit sequencer shared by the header and data frames; bit_cnt is the bit on the line.
    if (state == S_SYNC || state == S_SEND) begin
      if (baud_cnt != BAUD_LAST) begin
        baud_n = baud_cnt + 1'b1;
      end else begin
        baud_n = '0;
        if (bit_cnt == 4'd9) begin
          frame_done = 1'b1;
        end else begin
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            tx_n = 1'b1;
          end else begin
            tx_n    = shift_reg[0];
            shift_n = {1'b0, shift_reg[7:1]};
          end
        end
      end
    end

    case (state)
      S_IDLE: begin
        addr_n = '0;
        tx_n   = 1'b1;
        if (start) begin
          state_n = S_SYNC;
          shift_n = SYNC_BYTE;
          tx_n    = 1'b0;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      S_SYNC: begin
        if (frame_done) begin
          state_n = S_FETCH;
          addr_n  = '0;
          lat_n   = '0;
          bit_n   = '0;
        end
      end
      S_FETCH: begin
        if (lat_cnt == LAT_LAST) state_n = S_LOAD;
        else                     lat_n   = lat_cnt + 1'b1;
      end
      S_LOAD: begin
        word_n  = acc_out;
        byte_n  = '0;
        shift_n = acc_out[7:0];
        tx_n    = 1'b0;
        baud_n  = '0;
        bit_n   = '0;
        state_n = S_SEND;
      end
      S_SEND: begin
        if (frame_done) begin
          bit_n = '0;
          // Bytes of one word go back-to-back: next start bit follows the stop bit directly.
          if (byte_idx != BYTE_LAST) begin
            byte_n  = byte_inc;
            shift_n = word_reg[{byte_inc, 3'b000} +: 8];
            tx_n    = 1'b0;
          end else if (addr_acc == ADDR_LAST) begin
            state_n = S_DONE;
          end else begin
            addr_n  = addr_acc + 1'b1;
            lat_n   = '0;
            state_n = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_result_streamer.sv
// Scoreboard bench: two streamers (read latency 1 and 3) share one accumulator image;
// UART monitors decode each line and compare against queued hand-computed frames.
module tb_uart_result_streamer;

  localparam int CPB = 4;

  typedef struct {
    int         line;
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        busy1, done1, tx1, busy3, done3, tx3;
  logic [1:0]  addr1, addr3;
  logic [15:0] acc1, acc3;
  logic [1:0]  a3_d1, a3_d2;
  logic [1:0]  tx_bus, busy_bus, done_bus;

  logic [15:0] acc_mem   [4];
  logic [7:0]  exp_bytes [9];
  exp_t        exp_q[$];
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          done_cnt  [2];

  always #5 clk = ~clk;

  assign tx_bus   = {tx3, tx1};
  assign busy_bus = {busy3, busy1};
  assign done_bus = {done3, done1};

  uart_result_streamer #(.MATRIX_SIZE(2), .ACC_WIDTH(16), .CLK_PER_BIT(CPB),
                         .RD_LATENCY(1), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .addr_acc(addr1), .acc_out(acc1), .uart_tx(tx1));

  uart_result_streamer #(.MATRIX_SIZE(2), .ACC_WIDTH(16), .CLK_PER_BIT(CPB),
                         .RD_LATENCY(3), .SYNC_BYTE(8'hA5)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .addr_acc(addr3), .acc_out(acc3), .uart_tx(tx3));

  // Accumulator read models: data appears RD_LATENCY clocks after the address.
  always @(posedge clk) begin
    acc1  <= acc_mem[addr1];
    a3_d1 <= addr3;
    a3_d2 <= a3_d1;
    acc3  <= acc_mem[a3_d2];
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic push_dump(input int which, input int lat);
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.line = which;
      e.data = exp_bytes[i];
      e.gap  = (i == 0) ? -1 : (((i % 2) == 1) ? lat + 1 : 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input int which, input bit check_lat);
    @(posedge clk); #1;
    if (which == 0) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    if (check_lat) check_output("idle_before_start", tx_bus[which], 1);
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    @(negedge clk);
    if (check_lat) check_output("start_bit_latency", tx_bus[which], 0);
  endtask

  task automatic wait_idle(input int which, input int budget);
    int n = 0;
    while (busy_bus[which] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("dump_complete", busy_bus[which], 0);
    repeat (2) @(negedge clk);
  endtask

  // Decodes one line; checks byte value, bit widths, stop bit and idle gap per frame.
  task automatic monitor_line(input int which);
    int         gap = -1;
    logic [9:0] bits;
    bit         aborted, width_ok;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap = -1;
        continue;
      end
      if (tx_bus[which] == 1'b1) begin
        if (gap >= 0) gap++;
        continue;
      end
      aborted  = 1'b0;
      width_ok = 1'b1;
      bits     = '0;
      for (int b = 0; b < 10; b++) begin
        for (int s = 0; s < CPB; s++) begin
          if (!(b == 0 && s == 0)) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (aborted) break;
          if (s == 0) bits[b] = tx_bus[which];
          else if (tx_bus[which] !== bits[b]) width_ok = 1'b0;
        end
        if (aborted) break;
      end
      if (aborted) begin
        gap = -1;
        continue;
      end
      if (exp_q.size() == 0) begin
        check_output("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_output("frame_line", which, e.line);
        check_output("frame_byte", bits[8:1], e.data);
        check_output("frame_timing", {width_ok, bits[9]}, 2'b11);
        if (e.gap >= 0) check_output("frame_gap", gap, e.gap);
      end
      gap = 0;
    end
  endtask

  task automatic watch_done(input int which);
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check_output("busy_after_done", busy_bus[which], 0);
        pend = 1'b0;
      end
      if (!rst && done_bus[which]) begin
        done_cnt[which]++;
        check_output("busy_at_done", busy_bus[which], 1);
        pend = 1'b1;
      end
    end
  endtask

  initial monitor_line(0);
  initial monitor_line(1);
  initial watch_done(0);
  initial watch_done(1);

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    int n;
    acc_mem   = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
    exp_bytes = '{8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
    done_cnt  = '{0, 0};

    // Reset and idle hold
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_tx", tx1, 1);
    check_output("reset_busy", busy1, 0);
    check_output("reset_done", done1, 0);
    check_output("reset_addr", addr1, 0);
    check_output("reset_tx_lat3", tx3, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || addr1 !== 2'd0) bad++;
    end
    check_output("idle_hold", bad, 0);

    // Full dump with start-bit latency, bit widths and word gaps
    done_cnt[0] = 0;
    push_dump(0, 1);
    apply_stimulus(0, 1'b1);
    wait_idle(0, 1500);
    check_output("done_count_full", done_cnt[0], 1);
    check_output("queue_empty_full", exp_q.size(), 0);

    // Start re-pulsed while busy is ignored
    done_cnt[0] = 0;
    push_dump(0, 1);
    apply_stimulus(0, 1'b1);
    n = 0;
    while (addr1 !== 2'd1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_word2", addr1, 1);
    repeat (20) @(negedge clk);
    apply_stimulus(0, 1'b0);
    wait_idle(0, 1500);
    check_output("done_count_busy_start", done_cnt[0], 1);
    check_output("queue_empty_busy_start", exp_q.size(), 0);

    // Reset during data bit 3 of byte 0x34
    done_cnt[0] = 0;
    exp_q.push_back('{line: 0, data: 8'hA5, gap: -1});
    apply_stimulus(0, 1'b1);
    repeat (59) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("pre_reset_bit3", tx1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("post_reset_tx", tx1, 1);
    check_output("post_reset_busy", busy1, 0);
    check_output("post_reset_addr", addr1, 0);
    check_output("post_reset_no_done", done_cnt[0], 0);
    check_output("post_reset_queue", exp_q.size(), 0);
    push_dump(0, 1);
    apply_stimulus(0, 1'b1);
    wait_idle(0, 1500);
    check_output("done_count_after_reset", done_cnt[0], 1);
    check_output("queue_empty_after_reset", exp_q.size(), 0);

    // Read latency 3: same bytes, four-clock gap between words
    done_cnt[1] = 0;
    push_dump(1, 3);
    apply_stimulus(1, 1'b1);
    wait_idle(1, 1500);
    check_output("done_count_lat3", done_cnt[1], 1);
    check_output("queue_empty_lat3", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
